systolic_feeder: RTL

Front-end sequencer that drives the 8x8 systolic array on behalf of the upstream buffers. Per job it loads eight weight columns through the array's `load` one-hot interface, then streams activation rows with `input_valid`. It counts the result rows returned on `output_valid` and reports `done` and a sticky overflow flag. It sits between the weight/activation stream buffers (valid/ready) and the array's `load`/`input_value`/`input_valid` ports.

---
 rtl/systolic_pkg.sv | 7 +
 rtl/systolic_feeder.sv | 94 +++++++++
 2 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared array dimensions and feeder state encoding.
package systolic_pkg;
  localparam int ARRAY_DIM = 8;
  localparam int ELEM_W = 8;
  localparam int ROW_W = ARRAY_DIM * ELEM_W;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} feeder_state_t;
endpackage

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads weight columns, streams activation rows and counts results for the systolic array.
module systolic_feeder
  import systolic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           num_rows,
  input  logic                 float_mode,
  input  logic                 wt_valid,
  output logic                 wt_ready,
  input  logic [ROW_W-1:0]     wt_data,
  input  logic                 act_valid,
  output logic                 act_ready,
  input  logic [ROW_W-1:0]     act_data,
  output logic [ARRAY_DIM-1:0] arr_load,
  output logic [ROW_W-1:0]     arr_value,
  output logic                 arr_input_valid,
  output logic                 arr_float,
  input  logic                 arr_output_valid,
  input  logic                 arr_overflow,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf_sticky
);
  feeder_state_t r_state, w_next;
  logic [2:0] r_col;
  logic [7:0] r_sent, r_recv, r_num, w_recv_next;
  logic [ARRAY_DIM-1:0] r_load;
  logic [ROW_W-1:0] r_value;
  logic r_in_valid, r_float, r_ovf;
  logic w_start, w_wt_acc, w_act_acc, w_run, w_recv_inc;
  assign w_start = (r_state == IDLE) && start;
  assign wt_ready = r_state == LOAD_W;
  assign act_ready = (r_state == STREAM) && (r_sent < r_num);
  assign w_wt_acc = wt_valid && wt_ready;
  assign w_act_acc = act_valid && act_ready;
  assign w_run = (r_state == STREAM) || (r_state == DRAIN);
  // Result counter saturates at the job's row count; surplus pulses are dropped.
  assign w_recv_inc = arr_output_valid && w_run && (r_recv < r_num);
  assign w_recv_next = r_recv + {7'd0, w_recv_inc};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? LOAD_W : IDLE;
      LOAD_W:  w_next = (w_wt_acc && r_col == 3'd7) ? ((r_num == 8'd0) ? DONE : STREAM) : LOAD_W;
      STREAM:  w_next = (w_act_acc && r_sent + 8'd1 == r_num) ? DRAIN : STREAM;
      DRAIN:   w_next = (w_recv_next == r_num) ? DONE : DRAIN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_sent <= '0;
      r_recv <= '0;
      r_num <= '0;
      r_float <= 1'b0;
      r_ovf <= 1'b0;
      r_load <= '0;
      r_value <= '0;
      r_in_valid <= 1'b0;
    end else begin
      r_load <= w_wt_acc ? (8'b1 << r_col) : '0;
      r_value <= w_wt_acc ? wt_data : w_act_acc ? act_data : '0;
      r_in_valid <= w_act_acc;
      if (w_start) begin
        r_num <= num_rows;
        r_float <= float_mode;
        r_ovf <= 1'b0;
        r_col <= '0;
        r_sent <= '0;
        r_recv <= '0;
      end else begin
        r_col <= (w_wt_acc && r_col != 3'd7) ? r_col + 3'd1 : r_col;
        r_sent <= w_act_acc ? r_sent + 8'd1 : r_sent;
        r_recv <= w_recv_next;
        r_ovf <= r_ovf || (arr_overflow && w_run);
      end
    end
  end
  assign arr_load = r_load;
  assign arr_value = r_value;
  assign arr_input_valid = r_in_valid;
  assign arr_float = r_float;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign ovf_sticky = r_ovf;
endmodule
